// File: rtl/xbar_forward_rr_arbiter.sv
// xbar_forward_rr_arbiter: per-slave round-robin forward arbiter for crossbar AR/AW channels.
//
// Picks one master whose head request decodes to this slave, presents its
// number on grant_master_number, and qualifies the pop with push_to_fifo.
//
// Ports:
//   ACLK                rising-edge clock
//   ARESET              synchronous active-high reset
//   master_fifo_empty   per-master head-not-available flag (empty or ID-blocked)
//   master_dest_slave   per-master decoded destination of the head request
//   slave_fifo_full     this slave's address FIFO is full
//   wlast_accept        a WLAST beat entered this slave's W FIFO this cycle
//   grant_master_number currently granted master
//   push_to_fifo        granted master may pop into this slave's FIFO
//   lock_active         write lock held
//
// Optional feature macro: XBAR_FWD_ARB_WLOCK_EN
//   defined   : after an AW transfer the grant is held in LOCK until
//               wlast_accept, keeping AW and W order aligned (AW instances).
//   undefined : no LOCK state, wlast_accept unused, lock_active tied to 0
//               (AR instances).
module xbar_forward_rr_arbiter #(
    parameter int masters         = 2,
    parameter int slaves          = 2,
    parameter int MY_SLAVE_NUMBER = 0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [masters-1:0]         master_fifo_empty,
    input  logic [$clog2(slaves)-1:0]  master_dest_slave [masters],
    input  logic                       slave_fifo_full,
    input  logic                       wlast_accept,
    output logic [$clog2(masters)-1:0] grant_master_number,
    output logic                       push_to_fifo,
    output logic                       lock_active
);
    localparam int MW = $clog2(masters);
    localparam int SW = $clog2(slaves);
    localparam logic [SW-1:0] MY_SLAVE = SW'(MY_SLAVE_NUMBER);

    typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

`ifdef XBAR_FWD_ARB_WLOCK_EN
    localparam state_t AFTER_XFER = LOCK;
`else
    localparam state_t AFTER_XFER = IDLE;
`endif

    state_t            state, state_nxt;
    logic [MW-1:0]     rr_ptr, rr_nxt;
    logic [MW-1:0]     grant_reg, grant_nxt;
    logic              push_reg, push_nxt;
    logic [MW-1:0]     pick;
    logic              any_req;
    logic              xfer;
    logic [masters-1:0] req;

    always_comb begin
        req = '0;
        for (int i = 0; i < masters; i++)
            req[i] = ~master_fifo_empty[i] & (master_dest_slave[i] == MY_SLAVE);
    end

    // Scan from the highest offset down so the last hit is the first master
    // at or after rr_ptr in round-robin order.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int k = masters - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % masters]) begin
                pick    = MW'((int'(rr_ptr) + k) % masters);
                any_req = 1'b1;
            end
        end
    end

    // Qualify with the live request so a withdrawn head is never popped.
    assign push_to_fifo        = push_reg & req[grant_reg] & ~ARESET;
    assign xfer                = push_to_fifo & ~slave_fifo_full;
    assign grant_master_number = grant_reg;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_reg;
        push_nxt  = push_reg;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = pick;
                    push_nxt  = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    rr_nxt    = (grant_reg == MW'(masters - 1)) ? '0 : grant_reg + 1'b1;
                    push_nxt  = 1'b0;
                    state_nxt = AFTER_XFER;
                end else if (!req[grant_reg]) begin
                    push_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
`ifdef XBAR_FWD_ARB_WLOCK_EN
            LOCK: begin
                if (wlast_accept)
                    state_nxt = IDLE;
            end
`endif
            default: begin
                push_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_reg <= '0;
            push_reg  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            grant_reg <= grant_nxt;
            push_reg  <= push_nxt;
        end
    end

`ifdef XBAR_FWD_ARB_WLOCK_EN
    assign lock_active = (state == LOCK);
`else
    logic unused_wlast;
    assign unused_wlast = wlast_accept;
    assign lock_active  = 1'b0;
`endif
endmodule

// File: tb/tb_xbar_forward_rr_arbiter.sv
// tb_xbar_forward_rr_arbiter: scoreboard bench for the 2-master, slave-0 forward arbiter.
module tb_xbar_forward_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] fe;
    logic [0:0] dst [2];
    logic       full;
    logic       wl;
    logic [0:0] grant;
    logic       push;
    logic       lock;

    typedef struct {
        string tag;
        logic  g;
        logic  p;
        logic  l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;
    int   base;

    always #5 clk = ~clk;

    xbar_forward_rr_arbiter #(
        .masters(2),
        .slaves(2),
        .MY_SLAVE_NUMBER(0)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .master_fifo_empty(fe),
        .master_dest_slave(dst),
        .slave_fifo_full(full),
        .wlast_accept(wl),
        .grant_master_number(grant),
        .push_to_fifo(push),
        .lock_active(lock)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected for that cycle,
    // then compare them mid-cycle before the next rising edge.
    task automatic step(input string tag, input logic r, input logic [1:0] e,
                        input logic d0, input logic d1, input logic f, input logic w,
                        input logic eg, input logic ep, input logic el);
        exp_t x;
        rst    = r;
        fe     = e;
        dst[0] = d0;
        dst[1] = d1;
        full   = f;
        wl     = w;
        x.tag  = tag;
        x.g    = eg;
        x.p    = ep;
        x.l    = el;
        q.push_back(x);
        @(negedge clk);
        x = q.pop_front();
        check({x.tag, ".grant"}, 32'(grant), 32'(x.g));
        check({x.tag, ".push"},  32'(push),  32'(x.p));
        check({x.tag, ".lock"},  32'(lock),  32'(x.l));
        if (push && !full) xfers++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; fe = 2'b11; dst[0] = 1'b0; dst[1] = 1'b0; full = 1'b0; wl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("rst_hold", 1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        step("idle",     0, 2'b11, 0, 0, 0, 1, 0, 0, 0);
`ifdef XBAR_FWD_ARB_WLOCK_EN
        step("lk_req0",  0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        step("lk_gnt0",  0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        step("lk_hold1", 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        step("lk_hold2", 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        step("lk_wlast", 0, 2'b00, 0, 0, 0, 1, 0, 0, 1);
        step("lk_idle",  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("lk_gnt1",  0, 2'b00, 0, 0, 1, 0, 1, 1, 0);
        step("lk_wl_gr", 0, 2'b00, 0, 0, 1, 1, 1, 1, 0);
        step("lk_xfer1", 0, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        step("lk_lock1", 0, 2'b11, 0, 0, 0, 0, 1, 0, 1);
        step("lk_rst",   1, 2'b11, 0, 0, 0, 0, 1, 0, 1);
        step("lk_after", 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
`else
        step("m0_req",   0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        step("m0_gnt",   0, 2'b10, 0, 0, 0, 0, 0, 1, 0);
        step("m0_done",  0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        base = xfers;
        step("alt_i0",   0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("alt_g1a",  0, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        step("alt_i1",   0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        step("alt_g0a",  0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        step("alt_i2",   0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("alt_g1b",  0, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        step("alt_i3",   0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        step("alt_g0b",  0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        check("alt_xfers", 32'(xfers - base), 32'd4);
        base = xfers;
        step("full_idle", 0, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("full_stall", 0, 2'b00, 0, 0, 1, 0, 1, 1, 0);
        step("full_rel",  0, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        check("full_xfers", 32'(xfers - base), 32'd1);
        step("rr_idle",   0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        step("drop_gnt",  0, 2'b00, 0, 0, 1, 0, 0, 1, 0);
        step("drop_now",  0, 2'b01, 0, 0, 1, 0, 0, 0, 0);
        step("drop_idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("drop_rr",   0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        step("dest1_a",   0, 2'b01, 0, 1, 0, 0, 0, 0, 0);
        step("dest1_b",   0, 2'b01, 0, 1, 0, 1, 0, 0, 0);
`endif
        step("rg_req1",   0, 2'b01, 0, 0, 1, 0, 0, 0, 0);
        step("rg_gnt1",   0, 2'b01, 0, 0, 1, 0, 1, 1, 0);
        step("rg_rst",    1, 2'b01, 0, 0, 1, 0, 1, 0, 0);
        step("rg_after",  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("rg_rr0",    0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        step("end_idle",  0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
